// File: rtl/switch_debouncer_pkg.sv
// Shared constants for the slide-switch debouncer: board clock, debounce time,
// switch bit positions and the per-channel FSM state type.
package switch_debouncer_pkg;

    localparam int unsigned CLK_HZ      = 50_000_000;
    localparam int unsigned DEBOUNCE_MS = 10;
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = (CLK_HZ / 1000) * DEBOUNCE_MS;

    localparam int unsigned SW_ENABLE = 0;
    localparam int unsigned SW_SEL1   = 1;
    localparam int unsigned SW_SEL2   = 2;

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_COUNTING = 1'b1
    } db_state_e;

endpackage

// File: rtl/debounce_channel.sv
// One switch bit: two-flop synchronizer, stability counter FSM, and a registered
// output stage carrying the clean level and its edge pulses.
module debounce_channel
    import switch_debouncer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter logic        RESET_VALUE     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_raw,
    output logic sw_db,
    output logic sw_rise,
    output logic sw_fall,
    output logic evt
);

    localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_p0, sync_p1;
    db_state_e     state_p2, state_nxt;
    logic [CW-1:0] cnt_p2, cnt_nxt;
    logic          lvl_p2, lvl_nxt;
    logic          acc_p2, acc_nxt;
    logic          rise_nxt, fall_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0  <= RESET_VALUE;
            sync_p1  <= RESET_VALUE;
            state_p2 <= ST_STABLE;
            cnt_p2   <= '0;
            lvl_p2   <= RESET_VALUE;
            acc_p2   <= 1'b0;
            sw_db    <= RESET_VALUE;
            sw_rise  <= 1'b0;
            sw_fall  <= 1'b0;
        end else begin
            // p0/p1: synchronizer; p2: debounce FSM; outputs: registered level and pulses
            sync_p0  <= sw_raw;
            sync_p1  <= sync_p0;
            state_p2 <= state_nxt;
            cnt_p2   <= cnt_nxt;
            lvl_p2   <= lvl_nxt;
            acc_p2   <= acc_nxt;
            sw_db    <= lvl_p2;
            sw_rise  <= rise_nxt;
            sw_fall  <= fall_nxt;
        end
    end

    always_comb begin
        state_nxt = state_p2;
        cnt_nxt   = cnt_p2;
        acc_nxt   = 1'b0;
        case (state_p2)
            ST_STABLE: begin
                if (sync_p1 != lvl_p2) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        acc_nxt = 1'b1;
                    end else begin
                        state_nxt = ST_COUNTING;
                        cnt_nxt   = CW'(1);
                    end
                end
            end
            ST_COUNTING: begin
                if (sync_p1 == lvl_p2) begin
                    state_nxt = ST_STABLE;
                    cnt_nxt   = '0;
                end else if (cnt_p2 == CNT_LAST) begin
                    acc_nxt   = 1'b1;
                    state_nxt = ST_STABLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_p2 + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_STABLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        lvl_nxt  = acc_nxt ? sync_p1 : lvl_p2;
        rise_nxt = acc_p2 & lvl_p2;
        fall_nxt = acc_p2 & ~lvl_p2;
    end

    assign evt = acc_p2;

endmodule

// File: rtl/switch_debouncer.sv
// N independent debounced switch channels with a registered any-change flag
// aligned to the per-channel edge pulses.
module switch_debouncer
    import switch_debouncer_pkg::*;
#(
    parameter int unsigned    N               = 3,
    parameter int unsigned    DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter logic [N-1:0]   RESET_VALUE     = {N{1'b0}}
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] sw_raw,
    output logic [N-1:0] sw_db,
    output logic [N-1:0] sw_rise,
    output logic [N-1:0] sw_fall,
    output logic         sw_changed
);

    logic [N-1:0] evt;

    for (genvar i = 0; i < N; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VALUE     (RESET_VALUE[i])
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .sw_raw  (sw_raw[i]),
            .sw_db   (sw_db[i]),
            .sw_rise (sw_rise[i]),
            .sw_fall (sw_fall[i]),
            .evt     (evt[i])
        );
    end

    // Registered on the same edge the channels register their pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_changed <= 1'b0;
        end else begin
            sw_changed <= |evt;
        end
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed and random stimulus for switch_debouncer, checked each cycle against a
// window-based model: a level is reported DC+2 edges after DC equal raw samples.
module tb_switch_debouncer;
    import switch_debouncer_pkg::*;

    localparam int N    = 3;
    localparam int DC   = 8;
    localparam int HMAX = 8192;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] sw_raw = '1;
    logic [N-1:0] sw_db, sw_rise, sw_fall;
    logic         sw_changed;

    switch_debouncer #(
        .N               (N),
        .DEBOUNCE_CYCLES (DC),
        .RESET_VALUE     ({N{1'b0}})
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sw_raw     (sw_raw),
        .sw_db      (sw_db),
        .sw_rise    (sw_rise),
        .sw_fall    (sw_fall),
        .sw_changed (sw_changed)
    );

    always #5 clk = ~clk;

    int           checks = 0;
    int           fails  = 0;
    int           cyc    = 0;
    logic [N-1:0] raw_h [HMAX];
    bit           rst_h [HMAX];
    logic [N-1:0] m_db = '0, m_rise = '0, m_fall = '0;
    logic         m_chg = 1'b0;
    int           rise_cnt [N];
    int           fall_cnt [N];

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    // Acceptance rule: the DC raw samples captured at edges E-DC-2..E-3 all equal v,
    // v differs from the current level, and no reset touched edges E-DC-2..E.
    task automatic model_update();
        logic [N-1:0] prev;
        prev = m_db;
        if (rst_h[cyc]) begin
            m_db = '0;
        end else begin
            for (int ch = 0; ch < N; ch++) begin
                int s;
                bit ok;
                s  = cyc - DC - 2;
                ok = (s >= 1);
                if (ok) for (int k = s; k <= cyc; k++) if (rst_h[k]) ok = 0;
                if (ok) for (int k = s; k <= cyc - 3; k++)
                    if (raw_h[k][ch] !== raw_h[s][ch]) ok = 0;
                if (ok && raw_h[s][ch] !== prev[ch]) m_db[ch] = raw_h[s][ch];
            end
        end
        m_rise = rst_h[cyc] ? '0 : (m_db & ~prev);
        m_fall = rst_h[cyc] ? '0 : (~m_db & prev);
        m_chg  = |(m_rise | m_fall);
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        raw_h[cyc] = sw_raw;
        rst_h[cyc] = rst;
        model_update();
        #1;
        chk("sw_db", sw_db, m_db);
        chk("sw_rise", sw_rise, m_rise);
        chk("sw_fall", sw_fall, m_fall);
        chk("sw_changed", {{(N-1){1'b0}}, sw_changed}, {{(N-1){1'b0}}, m_chg});
        for (int ch = 0; ch < N; ch++) begin
            rise_cnt[ch] += int'(sw_rise[ch]);
            fall_cnt[ch] += int'(sw_fall[ch]);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clr_cnt();
        for (int ch = 0; ch < N; ch++) begin
            rise_cnt[ch] = 0;
            fall_cnt[ch] = 0;
        end
    endtask

    initial begin
        for (int k = 0; k < HMAX; k++) begin
            rst_h[k] = 1'b1;
            raw_h[k] = '0;
        end
        clr_cnt();

        // Reset held with all switches high
        run(3);
        chk("reset_db", sw_db, 3'b000);
        rst = 1'b0;
        step();
        run(9);
        chk("rst_rel_db_early", sw_db, 3'b000);
        step();
        chk("rst_rel_db", sw_db, 3'b111);
        chk("rst_rel_rise", sw_rise, 3'b111);
        chk("rst_rel_chg", {2'b00, sw_changed}, 3'b001);
        step();
        chk("rst_rel_chg_off", {2'b00, sw_changed}, 3'b000);

        sw_raw = 3'b000;
        run(12);

        // Clean press and release on switch1
        clr_cnt();
        sw_raw[SW_SEL1] = 1'b1;
        step();
        run(9);
        chk("press_db_early", sw_db, 3'b000);
        step();
        chk("press_db", sw_db, 3'b010);
        chk("press_rise", sw_rise, 3'b010);
        run(12);
        sw_raw[SW_SEL1] = 1'b0;
        run(10);
        chk("release_db_early", sw_db, 3'b010);
        step();
        chk("release_fall", sw_fall, 3'b010);
        run(12);
        chk("press_rise_cnt", 3'(rise_cnt[SW_SEL1]), 3'd1);
        chk("press_fall_cnt", 3'(fall_cnt[SW_SEL1]), 3'd1);

        // Glitch of DC-1 samples on enable, then a real press
        clr_cnt();
        sw_raw[SW_ENABLE] = 1'b1;
        run(DC - 1);
        sw_raw[SW_ENABLE] = 1'b0;
        run(15);
        chk("glitch_db", sw_db, 3'b000);
        chk("glitch_rise_cnt", 3'(rise_cnt[SW_ENABLE]), 3'd0);
        sw_raw[SW_ENABLE] = 1'b1;
        run(DC + 6);
        chk("glitch_accept_db", sw_db, 3'b001);
        chk("glitch_accept_cnt", 3'(rise_cnt[SW_ENABLE]), 3'd1);

        // Bounce on switch2 then hold high
        clr_cnt();
        for (int t = 0; t < 10; t++) begin
            sw_raw[SW_SEL2] = ~sw_raw[SW_SEL2];
            run(3);
        end
        sw_raw[SW_SEL2] = 1'b1;
        step();
        run(9);
        chk("bounce_db_early", sw_db & 3'b100, 3'b000);
        step();
        chk("bounce_rise", sw_rise, 3'b100);
        run(10);
        chk("bounce_rise_cnt", 3'(rise_cnt[SW_SEL2]), 3'd1);

        // Simultaneous rise on switch1 and switch2
        sw_raw = 3'b000;
        run(12);
        sw_raw = 3'b110;
        step();
        run(9);
        step();
        chk("simul_rise", sw_rise, 3'b110);
        chk("simul_chg", {2'b00, sw_changed}, 3'b001);
        step();
        chk("simul_chg_off", {2'b00, sw_changed}, 3'b000);

        // Reset while switch2 is mid-count
        sw_raw = 3'b000;
        run(12);
        clr_cnt();
        sw_raw[SW_SEL2] = 1'b1;
        run(7);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        run(9);
        chk("midrst_db_early", sw_db, 3'b000);
        chk("midrst_rise_cnt", 3'(rise_cnt[SW_SEL2]), 3'd0);
        step();
        chk("midrst_db", sw_db, 3'b100);

        // Random bursts with occasional single-cycle resets
        for (int b = 0; b < 80; b++) begin
            sw_raw = N'($urandom);
            if ($urandom_range(0, 24) == 0) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
            end
            run(int'($urandom_range(1, 13)));
        end
        run(DC + 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/switch_debouncer.md
# switch_debouncer

Conditions the board's raw slide switches before they reach the LED blink-rate selector. Each raw input passes through a two-flop synchronizer, then a per-channel stability counter. A level change is accepted only after it has held for DEBOUNCE_CYCLES consecutive clocks. Outputs are clean registered levels plus one-cycle edge pulses. Bit mapping: bit 0 = enable, bit 1 = switch1, bit 2 = switch2.

## Interface
- N, default 3: number of switch channels.
- DEBOUNCE_CYCLES, default 500000: required stable clocks, which is 10 ms at 50 MHz. Must be ≥ 1.
- RESET_VALUE, default {N{1'b0}}: per-channel reset level for synchronizer flops and debounced outputs.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous, active-high reset.
- sw_raw  in  N  asynchronous switch pins.
- sw_db  out  N  debounced level.
- sw_rise  out  N  one-cycle pulse when sw_db[i] goes 0→1.
- sw_fall  out  N  one-cycle pulse when sw_db[i] goes 1→0.
- sw_changed  out  1  OR of all sw_rise and sw_fall bits, registered in the same cycle as the pulses.

## Operation
- Synchronizer per channel: s1 ← sw_raw[i], then s2 ← s1.
- Stability counter width: CW = $clog2(DEBOUNCE_CYCLES+1). It never exceeds DEBOUNCE_CYCLES-1.
- Per-channel FSM has two states:
  - STABLE (cnt = 0). If s2 == sw_db[i], stay in STABLE. If they differ, cnt ← 1 and go to COUNTING.
  - COUNTING. If s2 == sw_db[i], cnt ← 0 and return to STABLE; the glitch is discarded. Else if cnt == DEBOUNCE_CYCLES-1, sw_db[i] ← s2, cnt ← 0, fire the matching rise/fall pulse, and go to STABLE. Else cnt ← cnt+1.
- DEBOUNCE_CYCLES = 1: a differing s2 is accepted on the first compare edge.
- Channels are fully independent. Simultaneous acceptances on several channels assert their pulses in the same cycle, and sw_changed is high for that single cycle.
- Pulses are high for exactly one cycle per accepted change.
- A bounce or glitch shorter than DEBOUNCE_CYCLES synchronized cycles never produces a pulse or an sw_db change.
- Reset (rst = 1 at a clk edge) sets:
  - s1, s2, sw_db ← RESET_VALUE
  - cnt ← 0, state STABLE
  - sw_rise, sw_fall, sw_changed ← 0
- Reset overrides any count in progress. After rst deasserts, a raw level differing from RESET_VALUE runs a full debounce and produces its pulse normally.

## Timing
- Latency: sw_db changes DEBOUNCE_CYCLES+2 clock edges after the first edge at which s1 captures the new raw level, provided the raw level holds throughout.
- Pulses and sw_changed assert in the same cycle that sw_db updates.
- All outputs are registered. There is no combinational path from sw_raw.
- Reset takes effect on the first clk edge with rst = 1. All outputs hold their reset values while rst is high.

## Structure
- Shared package/header holds these constants:
  - CLK_HZ = 50_000_000.
  - DEBOUNCE_MS = 10, giving the derived default DEBOUNCE_CYCLES.
  - Switch bit indices SW_ENABLE = 0, SW_SEL1 = 1, SW_SEL2 = 2.
- One sub-module, debounce_channel, contains the synchronizer, counter/FSM and edge pulse logic for a single bit.
- The top generates N instances and ORs the pulses into sw_changed.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 8 and RESET_VALUE = 0 in simulation.
- Reset: hold rst for 3 cycles with sw_raw = 3'b111 → sw_db = 000 and all pulses 0 during reset. After release, sw_db = 111 exactly 10 edges after the first post-reset sample, with sw_rise = 111 and sw_changed = 1 for one cycle.
- Clean press: sw_raw[1] 0→1 and held → sw_db[1] rises 10 edges after s1 capture. sw_rise[1] is high for one cycle and sw_fall stays 0. Release gives a symmetric result with a single sw_fall[1] pulse.
- Glitch rejection: sw_raw[0] high for 7 cycles then low → sw_db[0] stays 0 and no pulse. Then high for 8+ cycles → accepted, with one sw_rise[0].
- Bounce: sw_raw[2] toggles every 3 cycles for 30 cycles, then holds 1 → exactly one sw_rise[2], occurring 10 edges after the final transition is captured.
- Simultaneous: sw_raw[1] and sw_raw[2] rise in the same cycle → both sw_db bits update in the same cycle, sw_rise = 110, and sw_changed is high for exactly one cycle.
- Reset mid-count: sw_raw[2] goes high, rst pulses for 1 cycle when cnt = 5 → sw_db[2] stays 0 with no pulse. Acceptance occurs 10 edges after the first post-reset sample.
